// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// jtag_pkg : TAP state codes, op codes and TMS patterns for jtag_master
// Rev 1.0
// ============================================================================
package jtag_pkg;

  localparam logic [3:0] c_TAP_EX2DR = 4'h0;
  localparam logic [3:0] c_TAP_EX1DR = 4'h1;
  localparam logic [3:0] c_TAP_SHDR  = 4'h2;
  localparam logic [3:0] c_TAP_PAUDR = 4'h3;
  localparam logic [3:0] c_TAP_SELIR = 4'h4;
  localparam logic [3:0] c_TAP_UPDDR = 4'h5;
  localparam logic [3:0] c_TAP_CAPDR = 4'h6;
  localparam logic [3:0] c_TAP_SELDR = 4'h7;
  localparam logic [3:0] c_TAP_EX2IR = 4'h8;
  localparam logic [3:0] c_TAP_EX1IR = 4'h9;
  localparam logic [3:0] c_TAP_SHIR  = 4'hA;
  localparam logic [3:0] c_TAP_PAUIR = 4'hB;
  localparam logic [3:0] c_TAP_RTI   = 4'hC;
  localparam logic [3:0] c_TAP_UPDIR = 4'hD;
  localparam logic [3:0] c_TAP_CAPIR = 4'hE;
  localparam logic [3:0] c_TAP_TLR   = 4'hF;

  localparam logic [1:0] c_OP_TAP_RESET = 2'd0;
  localparam logic [1:0] c_OP_IDLE      = 2'd1;
  localparam logic [1:0] c_OP_SHIFT_IR  = 2'd2;
  localparam logic [1:0] c_OP_SHIFT_DR  = 2'd3;

  // TMS patterns are stored with the first TCK in bit 0
  localparam logic [5:0] c_TMS_RESET  = 6'b011111;
  localparam logic [3:0] c_TMS_PRE_IR = 4'b0011;
  localparam logic [2:0] c_TMS_PRE_DR = 3'b001;
  localparam logic [1:0] c_TMS_POST   = 2'b01;

  localparam logic [4:0] c_LAST_RESET  = 5'd5;
  localparam logic [4:0] c_LAST_PRE_IR = 5'd3;
  localparam logic [4:0] c_LAST_PRE_DR = 5'd2;
  localparam logic [4:0] c_LAST_POST   = 5'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] n;
    n = c_TAP_TLR;
    case (s)
      c_TAP_TLR:   n = tms ? c_TAP_TLR   : c_TAP_RTI;
      c_TAP_RTI:   n = tms ? c_TAP_SELDR : c_TAP_RTI;
      c_TAP_SELDR: n = tms ? c_TAP_SELIR : c_TAP_CAPDR;
      c_TAP_CAPDR: n = tms ? c_TAP_EX1DR : c_TAP_SHDR;
      c_TAP_SHDR:  n = tms ? c_TAP_EX1DR : c_TAP_SHDR;
      c_TAP_EX1DR: n = tms ? c_TAP_UPDDR : c_TAP_PAUDR;
      c_TAP_PAUDR: n = tms ? c_TAP_EX2DR : c_TAP_PAUDR;
      c_TAP_EX2DR: n = tms ? c_TAP_UPDDR : c_TAP_SHDR;
      c_TAP_UPDDR: n = tms ? c_TAP_SELDR : c_TAP_RTI;
      c_TAP_SELIR: n = tms ? c_TAP_TLR   : c_TAP_CAPIR;
      c_TAP_CAPIR: n = tms ? c_TAP_EX1IR : c_TAP_SHIR;
      c_TAP_SHIR:  n = tms ? c_TAP_EX1IR : c_TAP_SHIR;
      c_TAP_EX1IR: n = tms ? c_TAP_UPDIR : c_TAP_PAUIR;
      c_TAP_PAUIR: n = tms ? c_TAP_EX2IR : c_TAP_PAUIR;
      c_TAP_EX2IR: n = tms ? c_TAP_UPDIR : c_TAP_SHIR;
      c_TAP_UPDIR: n = tms ? c_TAP_SELDR : c_TAP_RTI;
      default:     n = c_TAP_TLR;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_master_if.sv
`default_nettype none
// ============================================================================
// jtag_master_if : command/response handshake and JTAG pins of jtag_master
// Rev 1.0
// ============================================================================
interface jtag_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        tck;
  logic        tms;
  logic        tdi;
  logic        tdo;
  logic [3:0]  tap_state;

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, tdo,
    output cmd_ready, rsp_valid, rsp_data, tck, tms, tdi, tap_state
  );

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, tdo,
    input  cmd_ready, rsp_valid, rsp_data, tck, tms, tdi, tap_state
  );
endinterface
`default_nettype wire

// File: rtl/jtag_tap_tracker.sv
`default_nettype none
// ============================================================================
// jtag_tap_tracker : follows the IEEE TAP state graph on each TCK rising edge
// Rev 1.0
// ============================================================================
module jtag_tap_tracker
  import jtag_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tms,
  input  logic       tck_rise,
  output logic [3:0] tap_state
);

  logic [3:0] r_state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= c_TAP_TLR;
    end else if (tck_rise) begin
      r_state <= tap_next(r_state, tms);
    end
  end

  assign tap_state = r_state;

endmodule
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
// jtag_master : command-driven JTAG controller, 32-bit shifts, TCK = CLK/2
// Rev 1.0
// ============================================================================
module jtag_master
  import jtag_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  jtag_master_if.slave bus
);

  ctrl_state_t r_state, w_state_nxt;
  logic [4:0]  r_cnt, w_cnt_nxt, w_last;
  logic [1:0]  r_op, w_op_nxt;
  logic [4:0]  r_len, w_len_nxt;
  logic [31:0] r_data, w_data_nxt, r_rsp;
  logic        r_boot, r_tck, r_tms, r_tdi;
  logic        w_active, w_rise, w_accept;
  logic [3:0]  w_tap_state;

  function automatic logic tms_of(input ctrl_state_t st, input logic [4:0] cnt,
                                  input logic [1:0] op, input logic [4:0] len);
    logic t;
    t = 1'b0;
    case (st)
      ST_PRE:
        case (op)
          c_OP_TAP_RESET: t = c_TMS_RESET[cnt[2:0]];
          c_OP_SHIFT_IR:  t = c_TMS_PRE_IR[cnt[1:0]];
          c_OP_SHIFT_DR:  t = c_TMS_PRE_DR[cnt[1:0]];
          default:        t = 1'b0;
        endcase
      ST_SHIFT: t = (cnt == len);
      ST_POST:  t = c_TMS_POST[cnt[0]];
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

  assign w_active = (r_state == ST_PRE) || (r_state == ST_SHIFT) || (r_state == ST_POST);
  assign w_rise   = w_active && !r_tck;
  assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;

  // Index of the final TCK in the current segment
  always_comb begin
    w_last = c_LAST_POST;
    case (r_state)
      ST_PRE:
        case (r_op)
          c_OP_TAP_RESET: w_last = c_LAST_RESET;
          c_OP_IDLE:      w_last = r_len;
          c_OP_SHIFT_IR:  w_last = c_LAST_PRE_IR;
          default:        w_last = c_LAST_PRE_DR;
        endcase
      ST_SHIFT: w_last = r_len;
      default:  w_last = c_LAST_POST;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_len_nxt   = r_len;
    w_data_nxt  = r_data;
    case (r_state)
      ST_IDLE:
        if (w_accept) begin
          w_state_nxt = ST_PRE;
          w_cnt_nxt   = '0;
          w_op_nxt    = bus.cmd_op;
          w_len_nxt   = bus.cmd_len;
          w_data_nxt  = bus.cmd_data;
        end
      ST_PRE, ST_SHIFT, ST_POST:
        // Segments advance at the end of each TCK high phase
        if (r_tck) begin
          if (r_cnt == w_last) begin
            w_cnt_nxt = '0;
            if (r_state == ST_SHIFT)
              w_state_nxt = ST_POST;
            else if (r_state == ST_POST)
              w_state_nxt = ST_DONE;
            else if ((r_op == c_OP_SHIFT_IR) || (r_op == c_OP_SHIFT_DR))
              w_state_nxt = ST_SHIFT;
            else if (r_boot)
              w_state_nxt = ST_IDLE;
            else
              w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + 5'd1;
          end
        end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset leaves the controller in the first low phase of its own TAP reset run
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_PRE;
      r_cnt   <= '0;
      r_op    <= c_OP_TAP_RESET;
      r_len   <= '0;
      r_data  <= '0;
      r_boot  <= 1'b1;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_len   <= w_len_nxt;
      r_data  <= w_data_nxt;
      r_tck   <= w_rise;
      r_tms   <= tms_of(w_state_nxt, w_cnt_nxt, w_op_nxt, w_len_nxt);
      r_tdi   <= (w_state_nxt == ST_SHIFT) ? w_data_nxt[w_cnt_nxt] : 1'b0;
      if (w_accept) begin
        r_boot <= 1'b0;
        r_rsp  <= '0;
      end else if (w_rise && (r_state == ST_SHIFT)) begin
        r_rsp[r_cnt] <= bus.tdo;
      end
    end
  end

  jtag_tap_tracker u_tracker (
    .CLK       (CLK),
    .RESET     (RESET),
    .tms       (r_tms),
    .tck_rise  (w_rise),
    .tap_state (w_tap_state)
  );

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_data  = r_rsp;
  assign bus.tck       = r_tck;
  assign bus.tms       = r_tms;
  assign bus.tdi       = r_tdi;
  assign bus.tap_state = w_tap_state;

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ============================================================================
// tb_jtag_master : scoreboard bench for jtag_master with a TCK-edge monitor
// Rev 1.0
// ============================================================================
module tb_jtag_master;
  import jtag_pkg::*;

  logic CLK;
  logic RESET;
  logic tdo_tie;
  int   n_tests;
  int   n_fail;
  int   rsp_cnt;
  logic prev_tck;

  logic [31:0] sb[$];
  logic        q_tms[$];
  logic        q_tdi[$];
  logic [3:0]  q_tap[$];

  jtag_master_if bus_if ();

  jtag_master dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_if)
  );

  assign bus_if.tdo = tdo_tie ? 1'b1 : bus_if.tdi;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Sample 2ns after each rising edge: record every TCK rise and check responses
  always begin
    @(posedge CLK);
    #2;
    if (!RESET) begin
      if (bus_if.tck && !prev_tck) begin
        q_tms.push_back(bus_if.tms);
        q_tdi.push_back(bus_if.tdi);
        q_tap.push_back(bus_if.tap_state);
      end
      if (bus_if.rsp_valid) begin
        rsp_cnt <= rsp_cnt + 1;
        if (sb.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else check("rsp_data", bus_if.rsp_data, sb.pop_front());
      end
    end
    prev_tck <= bus_if.tck;
  end

  function automatic logic [31:0] pack_bits(input int base, input int n, input bit use_tdi);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n && i < 32; i++) begin
      if (base + i < q_tms.size()) v[i] = use_tdi ? q_tdi[base + i] : q_tms[base + i];
    end
    return v;
  endfunction

  function automatic logic [31:0] tap_at(input int i);
    if (i < q_tap.size()) return {28'd0, q_tap[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic send(input logic [1:0] op, input logic [4:0] len,
                      input logic [31:0] data, input logic [31:0] exp, input bit hold);
    int t;
    t = 0;
    while (!bus_if.cmd_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    check("ready_wait", {31'd0, t < 200}, 32'd1);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op    = op;
    bus_if.cmd_len   = len;
    bus_if.cmd_data  = data;
    sb.push_back(exp);
    @(negedge CLK);
    if (!hold) bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int t;
    t = 0;
    while (!bus_if.rsp_valid && t < 400) begin
      @(negedge CLK);
      t++;
    end
    check(tag, {31'd0, t < 400}, 32'd1);
  endtask

  // Releases RESET at a falling edge and follows the autonomous TAP reset run
  task automatic boot_check(input string tag);
    int   b;
    int   r0;
    logic seen_ready;
    b = q_tms.size();
    r0 = rsp_cnt;
    seen_ready = 1'b0;
    RESET = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      if (i < 12 && bus_if.cmd_ready) seen_ready = 1'b1;
    end
    check({tag, "_early_ready"}, {31'd0, seen_ready}, 32'd0);
    check({tag, "_ready_clk13"}, {31'd0, bus_if.cmd_ready}, 32'd1);
    check({tag, "_ntck"}, q_tms.size() - b, 32'd6);
    check({tag, "_tms"}, pack_bits(b, 6, 1'b0), 32'h1F);
    check({tag, "_tap"}, {28'd0, bus_if.tap_state}, 32'd12);
    check({tag, "_no_rsp"}, rsp_cnt - r0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int t;
    n_tests = 0;
    n_fail  = 0;
    rsp_cnt = 0;
    prev_tck = 1'b0;
    tdo_tie = 1'b0;
    RESET = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op    = '0;
    bus_if.cmd_len   = '0;
    bus_if.cmd_data  = '0;

    repeat (3) @(negedge CLK);
    check("rst_tck", {31'd0, bus_if.tck}, 32'd0);
    check("rst_tms", {31'd0, bus_if.tms}, 32'd1);
    check("rst_tdi", {31'd0, bus_if.tdi}, 32'd0);
    check("rst_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
    check("rst_rsp_data", bus_if.rsp_data, 32'd0);
    check("rst_tap", {28'd0, bus_if.tap_state}, 32'd15);

    boot_check("boot");
    check("idle_tck_tms", {30'd0, bus_if.tck, bus_if.tms}, 32'd0);

    // SHIFT_DR 8 bits, loopback
    b = q_tms.size();
    send(c_OP_SHIFT_DR, 5'd7, 32'h0000_00A5, 32'h0000_00A5, 1'b0);
    wait_rsp("dr8_rsp_wait");
    check("dr8_ntck", q_tms.size() - b, 32'd13);
    check("dr8_tms", pack_bits(b, 13, 1'b0), 32'h0000_0C01);
    check("dr8_tdi", pack_bits(b, 13, 1'b1), 32'h0000_0528);
    check("dr8_tap0", tap_at(b), 32'd7);
    check("dr8_tap1", tap_at(b + 1), 32'd6);
    check("dr8_tap2", tap_at(b + 2), 32'd2);
    check("dr8_tap10", tap_at(b + 10), 32'd1);
    check("dr8_tap11", tap_at(b + 11), 32'd5);
    check("dr8_tap12", tap_at(b + 12), 32'd12);
    @(negedge CLK);
    check("dr8_pulse", {31'd0, bus_if.rsp_valid}, 32'd0);
    check("dr8_ready", {31'd0, bus_if.cmd_ready}, 32'd1);

    // SHIFT_IR single bit, tdo tied high
    tdo_tie = 1'b1;
    b = q_tms.size();
    send(c_OP_SHIFT_IR, 5'd0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_rsp("ir1_rsp_wait");
    check("ir1_ntck", q_tms.size() - b, 32'd7);
    check("ir1_tms", pack_bits(b, 7, 1'b0), 32'h0000_0033);
    check("ir1_tdi", pack_bits(b, 7, 1'b1), 32'h0000_0010);
    check("ir1_tap_selir", tap_at(b + 1), 32'd4);
    check("ir1_tap_ex1ir", tap_at(b + 4), 32'd9);
    check("ir1_tap_end", tap_at(b + 6), 32'd12);
    @(negedge CLK);
    tdo_tie = 1'b0;

    // SHIFT_DR full 32 bits, loopback
    b = q_tms.size();
    send(c_OP_SHIFT_DR, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    wait_rsp("dr32_rsp_wait");
    check("dr32_ntck", q_tms.size() - b, 32'd37);
    check("dr32_tdi", pack_bits(b + 3, 32, 1'b1), 32'hDEAD_BEEF);
    check("dr32_last_tms", pack_bits(b + 33, 4, 1'b0), 32'h0000_0006);
    @(negedge CLK);
    check("dr32_pulse", {31'd0, bus_if.rsp_valid}, 32'd0);

    // IDLE then SHIFT_DR with cmd_valid held high
    b = q_tms.size();
    send(c_OP_IDLE, 5'd3, 32'hFFFF_FFFF, 32'd0, 1'b1);
    bus_if.cmd_op   = c_OP_SHIFT_DR;
    bus_if.cmd_len  = 5'd3;
    bus_if.cmd_data = 32'h0000_0005;
    sb.push_back(32'h0000_0005);
    wait_rsp("b2b_rsp1_wait");
    check("b2b_idle_ntck", q_tms.size() - b, 32'd4);
    check("b2b_idle_tms", pack_bits(b, 4, 1'b0), 32'd0);
    check("b2b_idle_tdi", pack_bits(b, 4, 1'b1), 32'd0);
    @(negedge CLK);
    check("b2b_gap_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
    @(negedge CLK);
    check("b2b_accepted", {31'd0, bus_if.cmd_ready}, 32'd0);
    bus_if.cmd_valid = 1'b0;
    wait_rsp("b2b_rsp2_wait");
    @(negedge CLK);

    // Reset while shifting
    send(c_OP_SHIFT_DR, 5'd31, 32'h1234_5678, 32'h1234_5678, 1'b0);
    t = 0;
    while (bus_if.tap_state != 4'd2 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check("mid_reach_shdr", {31'd0, t < 100}, 32'd1);
    repeat (4) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_tck", {31'd0, bus_if.tck}, 32'd0);
    check("mid_rst_tms", {31'd0, bus_if.tms}, 32'd1);
    check("mid_rst_tdi", {31'd0, bus_if.tdi}, 32'd0);
    check("mid_rst_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
    check("mid_rst_rsp_data", bus_if.rsp_data, 32'd0);
    check("mid_rst_tap", {28'd0, bus_if.tap_state}, 32'd15);
    sb.delete();
    repeat (3) @(negedge CLK);
    boot_check("reboot");

    repeat (4) @(negedge CLK);
    check("sb_empty", sb.size(), 32'd0);
    check("rsp_total", rsp_cnt, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
